uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
//
// PURPOSE
//  Buffered UART transmitter: accepts words on a valid/ready stream, queues them in
//  an internal FIFO, serialises each as 8N1-style frames on tx (LSB first).
//  Outbound counterpart to the uart receive/latch path. Sits between on-board
//  producers (switches, test pattern, echo logic) and the JP1 tx pin.
//
// PARAMETERS
//  WORD_SIZE    8    data bits per frame
//  PULSE_WIDTH  434  clk cycles per bit (50 MHz / 115200 baud); legal range >= 2
//  FIFO_DEPTH   16   queue entries; power of two, >= 2
//
// PORTS
//  clk         in   1                     system clock (50 MHz)
//  rst         in   1                     asynchronous, active-high reset
//  in_valid    in   1                     producer has a word on in_data
//  in_data     in   WORD_SIZE             word to transmit
//  in_ready    out  1                     FIFO can accept; = !full
//  tx          out  1                     serial line, idle high, registered
//  busy        out  1                     FSM not IDLE (frame in progress)
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words queued (excludes word on the line)
//  drop        out  1                     1-cycle pulse: in_valid while !in_ready, word lost
//
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by caller): tx=1, busy=0, in_ready=1,
//    fifo_count=0, drop=0, FSM=IDLE, baud/bit counters=0, FIFO pointers=0.
//  - Reset mid-frame: line returns high immediately, partial frame abandoned, FIFO flushed.
//  - Push: in_valid && in_ready at edge N writes word. Push while full is ignored, drop=1.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> (IDLE | START).
//    IDLE: tx=1; if FIFO non-empty, pop into shift reg, go START.
//    START: tx=0 for PULSE_WIDTH cycles.
//    DATA: tx=shift[0], shift right every PULSE_WIDTH cycles, WORD_SIZE bits.
//    PARITY (macro only): tx=even parity of word, PULSE_WIDTH cycles.
//    STOP: tx=1 for PULSE_WIDTH cycles; on last cycle, if FIFO non-empty pop and
//    go directly to START (no idle gap), else IDLE.
//  - Latency: word pushed at edge N into empty FIFO, FSM IDLE -> popped at N+1,
//    tx low from edge N+2. Each bit held exactly PULSE_WIDTH cycles.
//  - Baud counter 0..PULSE_WIDTH-1, wraps on bit boundary; bit counter 0..WORD_SIZE-1.
//  - Simultaneous push+pop: count unchanged; push still requires !full before the edge.
//  - Pointers wrap modulo FIFO_DEPTH; full/empty from extra-bit pointer compare.
//  - in_data sampled only at push edge; changes afterwards have no effect.
//
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA, even parity,
//    frame = WORD_SIZE+3 bits.
//  Undefined: no PARITY state, frame = WORD_SIZE+2 bits; ports identical either way.
//
// TESTING (PULSE_WIDTH=434 unless stated)
//  1. Reset, push 0x06 -> tx low 434 cyc, then 0,1,1,0,0,0,0,0, stop 1; busy high 4340 cyc.
//  2. in_valid held with 0x00,0x01,... until in_ready falls -> exactly 17 accepted
//     (16 queued + 1 on line), 17 contiguous frames, no idle cycles between stop/start.
//  3. FIFO full, in_valid=1 with 0xAA for 3 cyc -> drop high 3 cyc, fifo_count stays 16,
//     0xAA never appears on tx.
//  4. Assert rst during DATA bit 3 of 0x55 with 5 queued -> tx=1 same cycle, busy=0,
//     fifo_count=0; after release push 0x3C -> clean frame 0x3C only.
//  5. UART_TX_PARITY_EN, push 0x07 -> parity bit 1, frame 4774 cyc; without macro 4340.
//  6. PULSE_WIDTH=4, random 200 words with random in_valid gaps -> scoreboard via
//     reference serial decoder matches order and values, zero drops when in_ready honoured.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. Words arrive on a valid/ready
//               stream, are queued in an internal FIFO, and are serialised
//               LSB first on tx as start / data / [parity] / stop frames.
//               The frame after a stop bit starts immediately when the FIFO
//               still holds data, so queued words go out back to back.
//
// Optional feature macro:
//   UART_TX_PARITY_EN  - inserts an even-parity bit after the data bits
//                        (frame = WORD_SIZE+3 bits instead of WORD_SIZE+2).
//                        The port list does not change.
//
// Parameters:
//   WORD_SIZE    data bits per frame
//   PULSE_WIDTH  clk cycles per bit, >= 2
//   FIFO_DEPTH   queue entries, power of two, >= 2
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   in_valid    producer presents a word on in_data
//   in_data     word to transmit, sampled only on the accepting edge
//   in_ready    FIFO can accept a word (not full)
//   tx          serial line, idle high, registered
//   busy        a frame is in progress
//   fifo_count  words waiting in the FIFO (the word on the line excluded)
//   drop        in_valid while the FIFO is full; the word is lost
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WORD_SIZE   = 8,
    parameter int PULSE_WIDTH = 434,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WORD_SIZE-1:0]        in_data,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        drop
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(PULSE_WIDTH);
    localparam int c_BW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(PULSE_WIDTH - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(WORD_SIZE - 1);
    localparam logic [c_CW-1:0] c_BAUD_ONE  = c_CW'(1);
    localparam logic [c_BW-1:0] c_BIT_ONE   = c_BW'(1);
    localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [c_AW:0]        wr_ptr_q;
    logic [c_AW:0]        wr_ptr_d;
    logic [c_AW:0]        rd_ptr_q;
    logic [c_AW:0]        rd_ptr_d;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [WORD_SIZE-1:0] w_head;

    // ------------------------------------------------------------------------
    // Transmit datapath
    // ------------------------------------------------------------------------
    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [c_CW-1:0]      baud_q;
    logic [c_CW-1:0]      baud_d;
    logic [c_BW-1:0]      bit_q;
    logic [c_BW-1:0]      bit_d;
    logic [WORD_SIZE-1:0] shift_q;
    logic [WORD_SIZE-1:0] shift_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
    logic                 parity_d;
`endif

    // The extra pointer bit separates "same slot, lapped" (full) from
    // "same slot, not lapped" (empty).
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_head  = mem_q[rd_ptr_q[c_AW-1:0]];

    assign w_bit_end = (baud_q == c_BAUD_LAST);

    assign in_ready   = !w_full;
    assign drop       = in_valid && w_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign busy       = (state_q != c_ST_IDLE);
    assign tx         = tx_q;

    // ------------------------------------------------------------------------
    // FIFO write port (storage is not reset; pointers define validity)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= in_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencer
    //
    // tx_d is derived from the current state, so the line lags the state by
    // one cycle: a pop at edge N+1 moves to START and drives the start bit
    // from edge N+2. Every state still lasts exactly PULSE_WIDTH cycles, so
    // each bit on the line does too.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        w_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != c_ST_IDLE) begin
            baud_d = w_bit_end ? '0 : (baud_q + c_BAUD_ONE);
        end

        case (state_q)
            c_ST_IDLE: begin
                tx_d = 1'b1;
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    shift_d  = w_head;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = c_ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^w_head;
`endif
                end
            end

            c_ST_START: begin
                tx_d = 1'b0;
                if (w_bit_end) begin
                    bit_d   = '0;
                    state_d = c_ST_DATA;
                end
            end

            c_ST_DATA: begin
                tx_d = shift_q[0];
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == c_BIT_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = c_ST_PARITY;
`else
                        state_d = c_ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + c_BIT_ONE;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                tx_d = parity_q;
                if (w_bit_end) begin
                    state_d = c_ST_STOP;
                end
            end
`endif

            c_ST_STOP: begin
                tx_d = 1'b1;
                if (w_bit_end) begin
                    // Chain straight into the next frame when data is waiting
                    // so there is no idle gap between stop and start bits.
                    if (!w_empty) begin
                        w_pop    = 1'b1;
                        shift_d  = w_head;
                        bit_d    = '0;
                        state_d  = c_ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^w_head;
`endif
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= c_ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire
